// File: rtl/text_pkg.sv
// Shared constants, control codes and FSM state type for the text-mode write controller.
package text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned CHAR_W = 7;
  localparam int unsigned ADDR_W = 12;

  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_FF = 7'h0C;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

endpackage

// File: rtl/text_write_ctrl_edge_pending.sv
// Per-bit rising-edge detector feeding a sticky pending flag, cleared when served.
module edge_pending #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] lvl,
  input  logic [W-1:0] clr,
  output logic [W-1:0] pend
);

  logic [W-1:0] lvl_q;
  logic [W-1:0] rise;

  assign rise = lvl & ~lvl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= '0;
      pend  <= '0;
    end else begin
      lvl_q <= lvl;
      // A fresh edge in the same cycle as a clear is kept, not lost.
      pend  <= (pend & ~clr) | rise;
    end
  end

endmodule

// File: rtl/text_write_ctrl.sv
// Text VRAM write-port controller: CPU/button arbitration, cursor tracking and screen clear.
// Optional cursor blink enabled by defining TEXT_CURSOR_BLINK_EN.
module text_write_ctrl #(
  parameter int unsigned        COLS      = text_pkg::COLS,
  parameter int unsigned        ROWS      = text_pkg::ROWS,
  parameter int unsigned        CHAR_W    = text_pkg::CHAR_W,
  parameter logic [CHAR_W-1:0]  CLR_CHAR  = CHAR_W'('h20),
  parameter int unsigned        BLINK_DIV = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic [CHAR_W-1:0] cpu_char,
  output logic              cpu_ready,
  input  logic [2:0]        btn,
  input  logic [CHAR_W-1:0] sw,
  output logic              we,
  output logic [11:0]       waddr,
  output logic [CHAR_W-1:0] wdata,
  output logic [6:0]        cur_x,
  output logic [4:0]        cur_y,
  output logic              busy,
  output logic              cursor_on
);
  import text_pkg::*;

  localparam logic [6:0]        X_MAX  = 7'(COLS - 1);
  localparam logic [4:0]        Y_MAX  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(COLS * ROWS - 1);

  state_t              state, nx_state;
  logic [6:0]          nx_x, adv_x;
  logic [4:0]          nx_y, adv_y;
  logic [ADDR_W-1:0]   addr_q, nx_addr, cur_addr;
  logic [CHAR_W-1:0]   data_q, nx_data;
  logic [2:0]          pend, pend_clr;

  edge_pending #(.W(3)) u_pend (
    .clk   (clk),
    .reset (reset),
    .lvl   (btn),
    .clr   (pend_clr),
    .pend  (pend)
  );

  assign cur_addr = ADDR_W'(cur_y) * ADDR_W'(COLS) + ADDR_W'(cur_x);
  assign adv_x    = (cur_x == X_MAX) ? '0 : cur_x + 7'd1;
  assign adv_y    = (cur_x != X_MAX) ? cur_y : (cur_y == Y_MAX) ? '0 : cur_y + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nx_state;
  end

  always_comb begin
    nx_state = state;
    nx_x     = cur_x;
    nx_y     = cur_y;
    nx_addr  = addr_q;
    nx_data  = data_q;
    pend_clr = '0;
    case (state)
      IDLE: begin
        // CPU has priority; a coincident button edge stays pending.
        if (cpu_valid) begin
          if (cpu_char == CHAR_W'(CH_LF)) begin
            nx_x = '0;
            nx_y = (cur_y == Y_MAX) ? '0 : cur_y + 5'd1;
          end else if (cpu_char == CHAR_W'(CH_BS)) begin
            if (cur_x != '0) begin
              nx_x = cur_x - 7'd1;
            end else if (cur_y != '0) begin
              nx_x = X_MAX;
              nx_y = cur_y - 5'd1;
            end
          end else if (cpu_char == CHAR_W'(CH_FF)) begin
            nx_state = CLEAR;
            nx_addr  = '0;
            nx_data  = CLR_CHAR;
          end else begin
            nx_state = WRITE;
            nx_addr  = cur_addr;
            nx_data  = cpu_char;
          end
        end else if (pend[2]) begin
          pend_clr[2] = 1'b1;
          nx_state    = CLEAR;
          nx_addr     = '0;
          nx_data     = CLR_CHAR;
        end else if (pend[0]) begin
          pend_clr[0] = 1'b1;
          nx_state    = WRITE;
          nx_addr     = cur_addr;
          nx_data     = sw;
        end else if (pend[1]) begin
          pend_clr[1] = 1'b1;
          nx_x        = adv_x;
          nx_y        = adv_y;
        end
      end
      WRITE: begin
        nx_state = IDLE;
        nx_x     = adv_x;
        nx_y     = adv_y;
      end
      CLEAR: begin
        if (addr_q == A_LAST) begin
          nx_state = IDLE;
          nx_x     = '0;
          nx_y     = '0;
        end else begin
          nx_addr = addr_q + 1'b1;
        end
      end
      default: nx_state = IDLE;
    endcase
  end

  always_comb begin
    we        = (state != IDLE);
    busy      = (state == CLEAR);
    cpu_ready = (state == IDLE) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x  <= '0;
      cur_y  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cur_x  <= nx_x;
      cur_y  <= nx_y;
      addr_q <= nx_addr;
      data_q <= nx_data;
    end
  end

  assign waddr = addr_q;
  assign wdata = data_q;

`ifdef TEXT_CURSOR_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_DIV);

  logic [BW-1:0] blink_cnt;
  logic          blink_q;
  logic          move;

  assign move = (nx_x != cur_x) || (nx_y != cur_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (move) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign cursor_on = blink_q;
`else
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign cursor_on        = 1'b1;
`endif

endmodule
